// File: rtl/ex_mdu_pkg.sv
// Shared constants for the ex_mdu execute-stage multiply/divide unit:
// funct3 op codes, FSM state encoding and op decode helpers.
package ex_mdu_pkg;

  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_FIX  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is signed for MULH, MULHSU, DIV and REM
  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
  endfunction

  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Handshake and operand bundle between the EX stage and the ex_mdu unit.
interface ex_mdu_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, rs1, rs2,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, kill, op, rs1, rs2,
    output busy, out_valid, result
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Iterative datapath for ex_mdu: one shift-add multiply step or one
// restoring-divide step per enabled cycle, on unsigned magnitudes.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   opnd_a,
  input  logic [XLEN-1:0]   opnd_b,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder,
  output logic              last
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [2*XLEN:0]  acc;
  logic [2*XLEN:0]  acc_next;
  logic [2*XLEN:0]  shifted;
  logic [XLEN:0]    hi;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    shi;
  logic [XLEN-1:0]  opnd_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;

  // Multiply shifts right with the partial sum in the upper half; divide
  // shifts the dividend left into the remainder and trial-subtracts.
  always_comb begin
    hi       = acc[2*XLEN:XLEN];
    sum      = hi + (acc[0] ? {1'b0, opnd_q} : '0);
    shifted  = {acc[2*XLEN-1:0], 1'b0};
    shi      = shifted[2*XLEN:XLEN];
    acc_next = {1'b0, sum, acc[XLEN-1:1]};
    if (mode_q) begin
      if (shi >= {1'b0, opnd_q})
        acc_next = {shi - {1'b0, opnd_q}, shifted[XLEN-1:1], 1'b1};
      else
        acc_next = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{(XLEN+1){1'b0}}, (div_mode ? opnd_a : opnd_b)};
      opnd_q <= div_mode ? opnd_b : opnd_a;
      mode_q <= div_mode;
      cnt    <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign product   = acc[2*XLEN-1:0];
  assign quotient  = acc[XLEN-1:0];
  assign remainder = acc[2*XLEN-1:XLEN];
  assign last      = (cnt == CNT_W'(XLEN - 1));

endmodule

// File: rtl/ex_mdu.sv
// RV M-extension execute unit: FSM, sign fix-up and special cases around
// mdu_iter_core. Define MDU_FAST_MUL_EN for single-cycle multiplies.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_mdu_if.slave mdu
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q;
  logic            neg_hi_q;
  logic            neg_rem_q;
  logic            div_zero_q;
  logic            ovf_q;
  logic            busy_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;

  logic              accept;
  logic              calc_step;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              ovf;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;
  logic              core_last;

  // Operand decode is only meaningful in the accepting cycle.
  always_comb begin
    accept    = (state == MDU_ST_IDLE) && mdu.start && !mdu.kill;
    calc_step = (state == MDU_ST_CALC);
    a_neg     = op_rs1_signed(mdu.op) && mdu.rs1[XLEN-1];
    b_neg     = op_rs2_signed(mdu.op) && mdu.rs2[XLEN-1];
    a_mag     = a_neg ? -mdu.rs1 : mdu.rs1;
    b_mag     = b_neg ? -mdu.rs2 : mdu.rs2;
    div_zero  = op_is_div(mdu.op) && (mdu.rs2 == '0);
    ovf       = op_is_div(mdu.op) && op_rs1_signed(mdu.op) &&
                (mdu.rs1 == MIN_INT) && (mdu.rs2 == '1);
  end

  mdu_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (calc_step),
    .div_mode  (op_is_div(mdu.op)),
    .opnd_a    (a_mag),
    .opnd_b    (b_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (core_last)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    if (a_neg ^ b_neg)
      fast_prod = -fast_prod;
    fast_res = (mdu.op == MDU_OP_MUL) ? fast_prod[XLEN-1:0]
                                      : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // Special cases override the (meaningless) iterative result in FIX.
  always_comb begin
    prod_fix = neg_hi_q  ? -product   : product;
    quot_fix = neg_hi_q  ? -quotient  : quotient;
    rem_fix  = neg_rem_q ? -remainder : remainder;
    fix_res  = '0;
    case (op_q)
      MDU_OP_MUL:
        fix_res = prod_fix[XLEN-1:0];
      MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU:
        fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_OP_DIV, MDU_OP_DIVU:
        fix_res = div_zero_q ? '1 : (ovf_q ? rs1_q : quot_fix);
      MDU_OP_REM, MDU_OP_REMU:
        fix_res = div_zero_q ? rs1_q : (ovf_q ? '0 : rem_fix);
      default:
        fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MDU_ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      neg_hi_q    <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        MDU_ST_IDLE: begin
          if (accept) begin
            op_q       <= mdu.op;
            rs1_q      <= mdu.rs1;
            neg_hi_q   <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= div_zero;
            ovf_q      <= ovf;
            busy_q     <= 1'b1;
`ifdef MDU_FAST_MUL_EN
            if (!op_is_div(mdu.op)) begin
              state       <= MDU_ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= fast_res;
            end else if (div_zero || ovf)
              state <= MDU_ST_FIX;
            else
              state <= MDU_ST_CALC;
`else
            if (div_zero || ovf)
              state <= MDU_ST_FIX;
            else
              state <= MDU_ST_CALC;
`endif
          end
        end
        MDU_ST_CALC: begin
          if (mdu.kill) begin
            state  <= MDU_ST_IDLE;
            busy_q <= 1'b0;
          end else if (core_last)
            state <= MDU_ST_FIX;
        end
        MDU_ST_FIX: begin
          if (mdu.kill) begin
            state  <= MDU_ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            state       <= MDU_ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= fix_res;
          end
        end
        MDU_ST_DONE: begin
          state  <= MDU_ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= MDU_ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy      = busy_q;
  assign mdu.out_valid = out_valid_q;
  assign mdu.result    = result_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu (XLEN=32); expected latencies
// follow MDU_FAST_MUL_EN when the bench is built with it.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT     = XLEN + 2;
  localparam int SPECIAL_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  ex_mdu_if #(.XLEN(XLEN)) mdu_bus ();

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one op, scrambles the inputs while busy, and waits (bounded) for out_valid.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int lat,
                                output logic [31:0] res, output logic busy_ok);
    @(negedge clk);
    mdu_bus.start = 1'b1;
    mdu_bus.op    = op;
    mdu_bus.rs1   = a;
    mdu_bus.rs2   = b;
    @(negedge clk);
    mdu_bus.start = 1'b0;
    mdu_bus.op    = ~op;
    mdu_bus.rs1   = ~a;
    mdu_bus.rs2   = b ^ 32'h5a5a_0f0f;
    lat     = 0;
    res     = mdu_bus.result;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (!mdu_bus.busy) busy_ok = 1'b0;
      if (mdu_bus.out_valid) begin
        lat = k;
        res = mdu_bus.result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int          lat;
    logic [31:0] res;
    logic        busy_ok;
    apply_stimulus(op, a, b, lat, res, busy_ok);
    check_output({tag, " result"}, res, exp_res);
    check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          seen;
    int          lat;
    int          busy_after;
    logic [31:0] res;

    rst           = 1'b1;
    mdu_bus.start = 1'b0;
    mdu_bus.kill  = 1'b0;
    mdu_bus.op    = 3'b000;
    mdu_bus.rs1   = '0;
    mdu_bus.rs2   = '0;
    repeat (2) @(negedge clk);
    check_output("reset busy", {31'b0, mdu_bus.busy}, 32'd0);
    check_output("reset out_valid", {31'b0, mdu_bus.out_valid}, 32'd0);
    check_output("reset result", mdu_bus.result, 32'h0000_0000);
    rst = 1'b0;

    run_op("MUL 7*-3", MDU_OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("MULHU max*max", MDU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("MULHSU -1*2", MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run_op("MULH -2*3", MDU_OP_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, MUL_LAT);
    run_op("MULH min*min", MDU_OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("DIV -7/2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("REM -7/2", MDU_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("DIVU 100/7", MDU_OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("REMU 100/7", MDU_OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);

    // Kill at T+10 of a DIV: idle at T+11, no pulse, result keeps 2.
    @(negedge clk);
    mdu_bus.start = 1'b1;
    mdu_bus.op    = MDU_OP_DIV;
    mdu_bus.rs1   = 32'd100;
    mdu_bus.rs2   = 32'd3;
    @(negedge clk);
    mdu_bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check_output("kill pre busy", {31'b0, mdu_bus.busy}, 32'd1);
    mdu_bus.kill = 1'b1;
    @(negedge clk);
    mdu_bus.kill = 1'b0;
    check_output("kill busy", {31'b0, mdu_bus.busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu_bus.out_valid) seen++;
      @(negedge clk);
    end
    check_output("kill out_valid", 32'(seen), 32'd0);
    check_output("kill result", mdu_bus.result, 32'd2);

    run_op("DIV 5/0", MDU_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("REM 5/0", MDU_OP_REM, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
    run_op("DIVU 9/0", MDU_OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("DIV ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
    run_op("REM ovf", MDU_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPECIAL_LAT);

    // start during busy must neither disturb nor queue.
    @(negedge clk);
    mdu_bus.start = 1'b1;
    mdu_bus.op    = MDU_OP_DIV;
    mdu_bus.rs1   = 32'd1000;
    mdu_bus.rs2   = 32'd10;
    @(negedge clk);
    mdu_bus.start = 1'b0;
    repeat (4) @(negedge clk);
    mdu_bus.start = 1'b1;
    mdu_bus.op    = MDU_OP_MUL;
    mdu_bus.rs1   = 32'd3;
    mdu_bus.rs2   = 32'd3;
    @(negedge clk);
    mdu_bus.start = 1'b0;
    lat = 0;
    res = 32'hDEAD_BEEF;
    for (int k = 6; k <= 100; k++) begin
      if (mdu_bus.out_valid) begin
        lat = k;
        res = mdu_bus.result;
        break;
      end
      @(negedge clk);
    end
    check_output("ignored start result", res, 32'd100);
    check_output("ignored start latency", 32'(lat), 32'(DIV_LAT));
    busy_after = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mdu_bus.busy) busy_after++;
    end
    check_output("no queued op", 32'(busy_after), 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    mdu_bus.start = 1'b1;
    mdu_bus.op    = MDU_OP_MULHU;
    mdu_bus.rs1   = 32'h1234_5678;
    mdu_bus.rs2   = 32'h9ABC_DEF0;
    @(negedge clk);
    mdu_bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst pre busy", {31'b0, mdu_bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst async busy", {31'b0, mdu_bus.busy}, 32'd0);
    check_output("rst async result", mdu_bus.result, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("DIVU after rst", MDU_OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("MUL 6*7", MDU_OP_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
